// File: rtl/irrigation_actuator_driver_if.sv
// Command/drive bundle between the irrigation controller and the actuator
// driver. The master side issues the four commands (E, Al, Bs, Vs) and
// observes the physical drive and status signals produced by the slave.
interface irrigation_actuator_driver_if;
    logic       E;
    logic       Al;
    logic       Bs;
    logic       Vs;
    logic       pump_on;
    logic       valve_on;
    logic       alarm_led;
    logic       fault;
    logic       busy;
    logic [1:0] state;

    modport master (
        output E, Al, Bs, Vs,
        input  pump_on, valve_on, alarm_led, fault, busy, state
    );

    modport slave (
        input  E, Al, Bs, Vs,
        output pump_on, valve_on, alarm_led, fault, busy, state
    );
endinterface

// File: rtl/irrigation_actuator_driver.sv
// Actuator stage for the irrigation controller. It turns the E/Al/Bs/Vs
// commands into pump and drip-valve drive with minimum on-time, dead time
// between activations, command priority, fault latching and an alarm blinker.
// Optional build macro: IRR_SYNC_EN adds a two-flop synchronizer on each
// command input (adds 2 cycles of latency); left undefined, commands must
// already be synchronous to clk.
module irrigation_actuator_driver #(
    parameter int MIN_ON     = 4,
    parameter int DEAD       = 2,
    parameter int BLINK_HALF = 3,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    irrigation_actuator_driver_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SPRINKLE = 2'd1,
        DRIP     = 2'd2,
        FAULT    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MIN_ON_LOAD = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD   = CNT_W'(DEAD - 1);
    localparam logic [CNT_W-1:0] BLINK_LOAD  = CNT_W'(BLINK_HALF - 1);

    // Command bits as seen by the state machine: {E, Al, Bs, Vs}
    logic [3:0] cmd_raw;
    logic [3:0] cmd;
    logic       e_in, al_in, bs_in, vs_in;

    assign cmd_raw = {bus.E, bus.Al, bus.Bs, bus.Vs};

`ifdef IRR_SYNC_EN
    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;

    // Two-stage synchronizer for commands coming from another clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= cmd_raw;
            sync2_reg <= sync1_reg;
        end
    end

    assign cmd = sync2_reg;
`else
    assign cmd = cmd_raw;
`endif

    assign {e_in, al_in, bs_in, vs_in} = cmd;

    state_t           state_reg,  state_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [CNT_W-1:0] blink_reg,  blink_next;
    logic             led_reg,    led_next;

    // State, dwell counter and blink registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            blink_reg <= '0;
            led_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            blink_reg <= blink_next;
            led_reg   <= led_next;
        end
    end

    // Next-state and dwell-counter logic; E and Bs&Vs override everything
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (e_in || (bs_in && vs_in)) begin
            state_next = FAULT;
            cnt_next   = '0;
        end else begin
            unique case (state_reg)
                FAULT: begin
                    state_next = IDLE;
                    cnt_next   = DEAD_LOAD;
                end
                IDLE: begin
                    // A pending dead time blocks any start, alarm or not
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - 1'b1;
                    end else if (!al_in) begin
                        if (bs_in) begin
                            state_next = SPRINKLE;
                            cnt_next   = MIN_ON_LOAD;
                        end else if (vs_in) begin
                            state_next = DRIP;
                            cnt_next   = MIN_ON_LOAD;
                        end
                    end
                end
                SPRINKLE, DRIP: begin
                    // Exit always goes through IDLE so a switch gets dead time
                    if (al_in) begin
                        state_next = IDLE;
                        cnt_next   = DEAD_LOAD;
                    end else if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - 1'b1;
                    end else if ((state_reg == SPRINKLE) ? !bs_in : !vs_in) begin
                        state_next = IDLE;
                        cnt_next   = DEAD_LOAD;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Alarm blinker: first Al cycle lights the LED, then it toggles every
    // BLINK_HALF cycles; FAULT forces the LED on separately at the output
    always_comb begin
        led_next   = 1'b0;
        blink_next = '0;
        if (al_in && (state_next != FAULT)) begin
            if (blink_reg == '0) begin
                led_next   = ~led_reg;
                blink_next = BLINK_LOAD;
            end else begin
                led_next   = led_reg;
                blink_next = blink_reg - 1'b1;
            end
        end
    end

    assign bus.pump_on   = (state_reg == SPRINKLE);
    assign bus.valve_on  = (state_reg == DRIP);
    assign bus.fault     = (state_reg == FAULT);
    assign bus.alarm_led = (state_reg == FAULT) || led_reg;
    assign bus.busy      = (state_reg != IDLE) || (cnt_reg != '0);
    assign bus.state     = state_reg;

endmodule

// File: tb/tb_irrigation_actuator_driver.sv
// Directed bench for irrigation_actuator_driver at default parameters.
module tb_irrigation_actuator_driver;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    irrigation_actuator_driver_if bus ();

    irrigation_actuator_driver #(
        .MIN_ON     (4),
        .DEAD       (2),
        .BLINK_HALF (3),
        .CNT_W      (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: got=%0h @%0t", tag, got, $time);
        end
    endtask

    // Advance one active edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic e, input logic al, input logic bs, input logic vs);
        bus.E  = e;
        bus.Al = al;
        bus.Bs = bs;
        bus.Vs = vs;
    endtask

    task automatic do_reset();
        set_cmd(0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [7:0] blink_exp [7];

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b1;
        set_cmd(0, 0, 0, 0);
        blink_exp = '{8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};

        // Reset state
        do_reset();
        check("rst_state", 8'(bus.state), 8'd0);
        check("rst_pump", 8'(bus.pump_on), 8'd0);
        check("rst_valve", 8'(bus.valve_on), 8'd0);
        check("rst_alarm", 8'(bus.alarm_led), 8'd0);
        check("rst_fault", 8'(bus.fault), 8'd0);
        check("rst_busy", 8'(bus.busy), 8'd0);

        // 1-cycle Bs pulse: pump held for MIN_ON=4 cycles, then dead time
        set_cmd(0, 0, 1, 0);
        tick();
        set_cmd(0, 0, 0, 0);
        check("pulse_state", 8'(bus.state), 8'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("pulse_pump%0d", i), 8'(bus.pump_on), 8'd1);
        end
        tick();
        check("pulse_pump_off", 8'(bus.pump_on), 8'd0);
        check("pulse_busy_dead", 8'(bus.busy), 8'd1);
        tick();
        tick();
        check("pulse_busy_end", 8'(bus.busy), 8'd0);

        // Bs held 10 cycles, then Vs: 2 dead cycles between pump and valve
        do_reset();
        set_cmd(0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("hold_pump%0d", i), 8'(bus.pump_on), 8'd1);
            check($sformatf("hold_valve%0d", i), 8'(bus.valve_on), 8'd0);
        end
        set_cmd(0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("dead_pump%0d", i), 8'(bus.pump_on), 8'd0);
            check($sformatf("dead_valve%0d", i), 8'(bus.valve_on), 8'd0);
        end
        tick();
        check("switch_valve", 8'(bus.valve_on), 8'd1);
        check("switch_pump", 8'(bus.pump_on), 8'd0);

        // Alarm during DRIP aborts the valve and blinks 1,1,1,0,0,0,1
        do_reset();
        set_cmd(0, 0, 0, 1);
        tick();
        tick();
        check("drip_valve", 8'(bus.valve_on), 8'd1);
        set_cmd(0, 1, 0, 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("blink%0d", i), 8'(bus.alarm_led), blink_exp[i]);
            check($sformatf("blink_valve%0d", i), 8'(bus.valve_on), 8'd0);
        end
        check("alarm_state", 8'(bus.state), 8'd0);
        set_cmd(0, 0, 0, 0);
        tick();
        check("alarm_clear", 8'(bus.alarm_led), 8'd0);

        // E during SPRINKLE: fault in one cycle, then 2 dead cycles
        do_reset();
        set_cmd(0, 0, 1, 0);
        tick();
        tick();
        set_cmd(1, 0, 1, 0);
        tick();
        check("err_state", 8'(bus.state), 8'd3);
        check("err_fault", 8'(bus.fault), 8'd1);
        check("err_alarm", 8'(bus.alarm_led), 8'd1);
        check("err_pump", 8'(bus.pump_on), 8'd0);
        set_cmd(0, 0, 1, 0);
        tick();
        check("err_idle", 8'(bus.state), 8'd0);
        check("err_dead0", 8'(bus.pump_on), 8'd0);
        tick();
        check("err_dead1", 8'(bus.pump_on), 8'd0);
        tick();
        check("err_restart", 8'(bus.pump_on), 8'd1);

        // Bs&Vs from IDLE is illegal; dropping Vs leads back to SPRINKLE
        do_reset();
        set_cmd(0, 0, 1, 1);
        tick();
        check("ill_state", 8'(bus.state), 8'd3);
        check("ill_pump", 8'(bus.pump_on), 8'd0);
        set_cmd(0, 0, 1, 0);
        tick();
        check("ill_idle0", 8'(bus.state), 8'd0);
        tick();
        check("ill_idle1", 8'(bus.state), 8'd0);
        tick();
        check("ill_sprinkle", 8'(bus.state), 8'd1);

        // Asynchronous reset mid-SPRINKLE clears outputs without an edge
        do_reset();
        set_cmd(0, 0, 1, 0);
        tick();
        tick();
        check("ares_pre", 8'(bus.pump_on), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ares_pump", 8'(bus.pump_on), 8'd0);
        check("ares_state", 8'(bus.state), 8'd0);
        check("ares_busy", 8'(bus.busy), 8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ares_restart", 8'(bus.pump_on), 8'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
